// File: rtl/strober_fifo2.sv
// strober_fifo2 -- two-entry sample FIFO for the interpolation strober.
//
// Ports:
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset (empties the FIFO)
//   flush      synchronous empty request (dominates push/pop)
//   push       write push_data at the tail (caller guarantees count<2 or a same-cycle pop)
//   pop        drop the head entry (caller guarantees count>0)
//   push_data  sample to write
//   count      number of valid entries, 0..2
//   head       oldest entry, valid whenever count>0
module strober_fifo2 #(
  parameter int DWIDTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] push_data,
  output logic [1:0]        count,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  // Storage needs no reset: an entry is only ever read after it was written.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (push && !flush && (r_wr_ptr == 1'(gi))) begin
        r_mem[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) r_wr_ptr <= ~r_wr_ptr;
      if (pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;   // idle, or push+pop leaves occupancy unchanged
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/cic_interp_strober.sv
// cic_interp_strober -- input-rate strobe generator and sample feeder for a
// CIC interpolator. Divides the output-rate enable (strobe_fast) by rate to
// produce strobe_slow, pulls one buffered sample per strobe_slow, and fills the
// other output slots with zeros (hold_mode=0) or the last sample (hold_mode=1).
//
// Ports:
//   clock, reset_n        clock / asynchronous active-low reset
//   enable                run when high; flush and rearm when low
//   rate [WIDTH]          interpolation ratio (0 and 1 both mean 1), sampled while disabled
//   hold_mode             0 = zero-stuff, 1 = repeat last sample
//   strobe_fast           output-rate clock enable
//   strobe_slow           input-rate strobe (combinational)
//   in_data/in_valid/in_ready   upstream sample handshake
//   out_data/out_valid    interpolated sample stream, one clock after each strobe_fast
//   underrun              sticky: a sample was due while the buffer was empty
//   clear_underrun        clears underrun (a same-cycle set wins)
module cic_interp_strober #(
  parameter int WIDTH  = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [WIDTH-1:0]  rate,
  input  logic              hold_mode,
  input  logic              strobe_fast,
  output logic              strobe_slow,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              underrun,
  input  logic              clear_underrun
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);   // counter reload / minimum rate

  logic [WIDTH-1:0]  r_rate_q;
  logic [WIDTH-1:0]  r_cnt;
  logic [DWIDTH-1:0] r_out_data;
  logic [DWIDTH-1:0] r_hold;
  logic              r_out_valid;
  logic              r_underrun;

  logic [WIDTH-1:0]  w_rate_eff;
  logic              w_fast_run;
  logic              w_slow;
  logic              w_push;
  logic              w_pop;
  logic              w_underrun_set;
  logic [1:0]        w_count;
  logic [DWIDTH-1:0] w_head;

  assign w_rate_eff = (r_rate_q <= C_ONE) ? C_ONE : r_rate_q;
  assign w_fast_run = enable & strobe_fast;
  // reset_n gating keeps the combinational outputs quiet while reset is held.
  assign w_slow     = reset_n & w_fast_run & (r_cnt == C_ONE);
  assign in_ready   = reset_n & enable & (w_count < 2'd2);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = w_slow & (w_count != 2'd0);
  assign w_underrun_set = w_slow & (w_count == 2'd0);

  strober_fifo2 #(
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (~enable),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (in_data),
    .count     (w_count),
    .head      (w_head)
  );

  // Rate is only sampled while disabled so the period cannot change mid-stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rate_q <= C_ONE;
    end else if (!enable) begin
      r_rate_q <= rate;
    end
  end

  // Counter parks at 1 while disabled so the first strobe_fast after enable is a slow strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= C_ONE;
    end else if (!enable) begin
      r_cnt <= C_ONE;
    end else if (strobe_fast) begin
      r_cnt <= (r_cnt == C_ONE) ? w_rate_eff : r_cnt - C_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
    end else if (!enable) begin
      r_out_data  <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= strobe_fast;
      if (strobe_fast) begin
        if (w_slow) begin
          // Empty buffer on a due sample emits a zero rather than stale data.
          r_out_data <= w_pop ? w_head : '0;
          r_hold     <= w_pop ? w_head : '0;
        end else begin
          r_out_data <= hold_mode ? r_hold : '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (clear_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign strobe_slow = w_slow;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_cic_interp_strober.sv
// Directed self-checking bench for cic_interp_strober.
module tb_cic_interp_strober;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  rate = 8'd4;
  logic        hold_mode = 1'b0;
  logic        strobe_fast = 1'b1;
  logic        strobe_slow;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        underrun;
  logic        clear_underrun = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] A  = 16'hA1A1;
  localparam logic [15:0] B  = 16'hB2B2;
  localparam logic [15:0] C  = 16'hC3C3;
  localparam logic [15:0] D1 = 16'h0D01;
  localparam logic [15:0] D2 = 16'h0D02;
  localparam logic [15:0] D3 = 16'h0D03;
  localparam logic [15:0] E1 = 16'h0E01;
  localparam logic [15:0] E2 = 16'h0E02;

  logic [15:0] exp_zero [9];
  logic [15:0] exp_hold [9];
  logic [15:0] exp_full [9];

  cic_interp_strober #(
    .WIDTH  (8),
    .DWIDTH (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .rate           (rate),
    .hold_mode      (hold_mode),
    .strobe_fast    (strobe_fast),
    .strobe_slow    (strobe_slow),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .underrun       (underrun),
    .clear_underrun (clear_underrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Preload A,B, then run 9 fast strobes at rate 4, pushing C on cycle 1.
  task automatic run_abc(input logic hm);
    enable = 1'b1;
    hold_mode = hm;
    strobe_fast = 1'b0;
    in_valid = 1'b1;
    in_data = A;
    settle();
    chk("abc_ready_empty", in_ready, 1);
    tick();
    in_data = B;
    tick();
    in_valid = 1'b0;
    settle();
    chk("abc_ready_full", in_ready, 0);
    strobe_fast = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) begin
        in_valid = 1'b1;
        in_data = C;
      end
      settle();
      chk($sformatf("abc_slow_hm%0d_k%0d", hm, k), strobe_slow, (k % 4 == 0) ? 1 : 0);
      tick();
      in_valid = 1'b0;
      chk($sformatf("abc_data_hm%0d_k%0d", hm, k), out_data, hm ? exp_hold[k] : exp_zero[k]);
      chk($sformatf("abc_valid_hm%0d_k%0d", hm, k), out_valid, 1);
    end
    strobe_fast = 1'b0;
    tick();
    chk("abc_keep_data", out_data, C);
    chk("abc_idle_valid", out_valid, 0);
  endtask

  initial begin
    exp_zero = '{A, 16'h0, 16'h0, 16'h0, B, 16'h0, 16'h0, 16'h0, C};
    exp_hold = '{A, A, A, A, B, B, B, B, C};
    exp_full = '{D1, D1, D2, D2, D2, D3, D3, D3, 16'h0};

    // Reset with enable/strobe_fast/in_valid all high.
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobe_slow", strobe_slow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_underrun", underrun, 0);
    tick();
    chk("rst_out_valid_edge", out_valid, 0);
    enable = 1'b0;
    in_valid = 1'b0;
    strobe_fast = 1'b0;
    reset_n = 1'b1;
    tick();

    // Zero-stuff then hold-mode at rate 4.
    run_abc(1'b0);
    enable = 1'b0;
    tick();
    chk("dis_out_data", out_data, 0);
    chk("dis_out_valid", out_valid, 0);
    run_abc(1'b1);

    // Underrun at rate 3; set wins over clear.
    enable = 1'b0;
    hold_mode = 1'b0;
    rate = 8'd3;
    tick();
    enable = 1'b1;
    strobe_fast = 1'b1;
    settle();
    chk("ur_first_slow", strobe_slow, 1);
    tick();
    chk("ur_out_data", out_data, 0);
    chk("ur_set", underrun, 1);
    tick();
    tick();
    chk("ur_sticky", underrun, 1);
    clear_underrun = 1'b1;
    settle();
    chk("ur_second_slow", strobe_slow, 1);
    tick();
    chk("ur_set_wins", underrun, 1);
    tick();
    chk("ur_cleared", underrun, 0);
    clear_underrun = 1'b0;

    // rate 0 and rate 1 both strobe every fast cycle.
    for (int r = 0; r < 2; r++) begin
      strobe_fast = 1'b0;
      enable = 1'b0;
      rate = 8'(r);
      tick();
      enable = 1'b1;
      strobe_fast = 1'b1;
      for (int k = 0; k < 3; k++) begin
        settle();
        chk($sformatf("rate%0d_slow_k%0d", r, k), strobe_slow, 1);
        tick();
      end
    end

    // Rate change while enabled is ignored until an enable toggle.
    enable = 1'b0;
    rate = 8'd4;
    tick();
    enable = 1'b1;
    rate = 8'd2;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk($sformatf("frozen_rate_k%0d", k), strobe_slow, (k % 4 == 0) ? 1 : 0);
      tick();
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("new_rate_k%0d", k), strobe_slow, (k % 2 == 0) ? 1 : 0);
      tick();
    end

    // FIFO full backpressure, no loss or duplication (rate 3, hold mode).
    strobe_fast = 1'b0;
    enable = 1'b0;
    rate = 8'd3;
    hold_mode = 1'b1;
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    enable = 1'b1;
    in_valid = 1'b1;
    in_data = D1;
    tick();
    in_data = D2;
    tick();
    in_data = D3;
    settle();
    chk("full_ready0", in_ready, 0);
    tick();
    chk("full_ready0_held", in_ready, 0);
    strobe_fast = 1'b1;
    settle();
    chk("full_pop_slow", strobe_slow, 1);
    tick();
    strobe_fast = 1'b0;
    chk("full_pop_data", out_data, D1);
    chk("full_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    settle();
    chk("full_ready_refilled", in_ready, 0);
    strobe_fast = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("full_seq_k%0d", k), out_data, exp_full[k]);
    end

    // Disable mid-period at counter 2 with one entry queued.
    strobe_fast = 1'b0;
    enable = 1'b0;
    rate = 8'd4;
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    chk("mid_underrun_clr", underrun, 0);
    enable = 1'b1;
    in_valid = 1'b1;
    in_data = E1;
    tick();
    in_data = E2;
    tick();
    in_valid = 1'b0;
    strobe_fast = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_before_data", out_data, E1);
    enable = 1'b0;
    tick();
    chk("mid_flush_data", out_data, 0);
    chk("mid_flush_valid", out_valid, 0);
    chk("mid_flush_underrun", underrun, 0);
    enable = 1'b1;
    settle();
    chk("mid_rearm_slow", strobe_slow, 1);
    tick();
    chk("mid_rearm_data", out_data, 0);
    chk("mid_rearm_underrun", underrun, 1);
    enable = 1'b0;
    tick();
    chk("mid_underrun_hold_dis", underrun, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
